// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Purpose  : Shares a single UART TX pin between N_REQ byte-stream
//            requesters. Round-robin arbitration with packet lock: a granted
//            requester owns the line until it sends a byte flagged last.
//            Contains the 8N1 (or 8E1) frame sequencer and baud counter.
// Config   : define UART_TX_PARITY_EN to insert an even-parity bit between
//            the last data bit and the stop bit (frame = 11 bit times).
// Ports    : clk          - system clock, rising edge
//            reset        - asynchronous, active-low reset
//            io_req_valid - per-requester byte valid
//            io_req_data  - byte of requester i on [8i+7:8i]
//            io_req_last  - byte of requester i ends its packet
//            io_req_ready - byte of requester i accepted this cycle
//            io_grant     - one-hot current owner, 0 when unlocked
//            io_busy      - frame in progress
//            io_tx        - serial output, idle high
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
  parameter int N_REQ        = 2,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   io_req_valid,
  input  logic [8*N_REQ-1:0] io_req_data,
  input  logic [N_REQ-1:0]   io_req_last,
  output logic [N_REQ-1:0]   io_req_ready,
  output logic [N_REQ-1:0]   io_grant,
  output logic               io_busy,
  output logic               io_tx
);

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t             state;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         data_q;
  logic               last_q;
  logic [IDX_W-1:0]   owner;
  logic               locked;
  logic [IDX_W-1:0]   rr;

  logic [IDX_W-1:0]   sel;
  logic               sel_found;
  logic               accept;
  logic [7:0]         sel_data;
  logic               bit_done;

  // Requester index rr+k wrapped into 0..N_REQ-1 (N_REQ need not be a power of two).
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Selection: the locked owner keeps the line; otherwise scan from rr+1.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    if (locked) begin
      sel       = owner;
      sel_found = io_req_valid[owner];
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        if (!sel_found && io_req_valid[wrap_idx(rr, k)]) begin
          sel_found = 1'b1;
          sel       = wrap_idx(rr, k);
        end
      end
    end
  end

  // Ready is combinational, so it is gated by reset to stay low while reset
  // is asserted even though the state register already reads IDLE.
  assign accept   = reset && (state == ST_IDLE) && sel_found;
  assign sel_data = io_req_data[{sel, 3'b000} +: 8];
  assign bit_done = (baud_cnt == BAUD_LAST);

  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_ready
      assign io_req_ready[i] = accept && (sel == IDX_W'(i));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      owner    <= '0;
      locked   <= 1'b0;
      rr       <= IDX_W'(N_REQ - 1);
      io_grant <= '0;
      io_busy  <= 1'b0;
      io_tx    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            data_q   <= sel_data;
            last_q   <= io_req_last[sel];
            owner    <= sel;
            locked   <= 1'b1;
            io_grant <= onehot(sel);
            baud_cnt <= '0;
            io_busy  <= 1'b1;
            io_tx    <= 1'b0;
            state    <= ST_START;
          end
        end

        ST_START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            io_tx    <= data_q[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              io_tx <= ^data_q;
              state <= ST_PARITY;
`else
              io_tx <= 1'b1;
              state <= ST_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              io_tx   <= data_q[bit_cnt + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_done) begin
            baud_cnt <= '0;
            io_tx    <= 1'b1;
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            io_busy  <= 1'b0;
            state    <= ST_IDLE;
            // Packet ends: release the line and restart the search after the owner.
            if (last_q) begin
              locked   <= 1'b0;
              io_grant <= '0;
              rr       <= owner;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          baud_cnt <= '0;
          io_busy  <= 1'b0;
          io_tx    <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
